// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared mode/state encodings and the per-digit clamp helper
// for the BCD stopwatch counter.
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    MODE_UP_ZERO = 2'b00,
    MODE_UP_INIT = 2'b01,
    MODE_DN_NINE = 2'b10,
    MODE_DN_INIT = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_step.sv
// bcd_digit_step: one BCD digit of the ripple counter; steps up or down by one
// when cin is set and signals carry/borrow on rollover.
`default_nettype none

module bcd_digit_step (
  input  logic [3:0] digit,
  input  logic       dir,
  input  logic       cin,
  output logic [3:0] next,
  output logic       cout
);

  // dir = 0 counts up, dir = 1 counts down
  always_comb begin
    next = digit;
    cout = 1'b0;
    if (cin) begin
      if (!dir) begin
        if (digit >= 4'd9) begin
          next = 4'd0;
          cout = 1'b1;
        end else begin
          next = digit + 4'd1;
        end
      end else begin
        if (digit == 4'd0) begin
          next = 4'd9;
          cout = 1'b1;
        end else begin
          next = digit - 4'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: loadable up/down packed-BCD stopwatch with IDLE/RUN/DONE
// control, driven by an external tick timebase.
`default_nettype none

module stopwatch_counter #(
  parameter int DIGITS = 4,
  parameter int W      = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   mode,
  input  logic [W-1:0] init_bcd,
  input  logic         load,
  input  logic         start,
  input  logic         stop,
  input  logic         tick,
  output logic [W-1:0] count_bcd,
  output logic         running,
  output logic         done
);

  import stopwatch_pkg::*;

  state_t       state;
  mode_t        mode_q;
  logic         dir;
  logic [DIGITS:0] carry;
  logic [W-1:0] step_bcd;
  logic [W-1:0] preset;
  logic         wrap;
  logic         next_term;

  assign dir      = (mode_q == MODE_DN_NINE) || (mode_q == MODE_DN_INIT);
  assign carry[0] = 1'b1;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_step u_step (
        .digit (count_bcd[4*i +: 4]),
        .dir   (dir),
        .cin   (carry[i]),
        .next  (step_bcd[4*i +: 4]),
        .cout  (carry[i+1])
      );
    end
  endgenerate

  // A ripple out of the top digit means the current count is already terminal.
  assign wrap = carry[DIGITS];

  always_comb begin
    next_term = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (step_bcd[4*i +: 4] != (dir ? 4'd0 : 4'd9)) next_term = 1'b0;
    end
  end

  always_comb begin
    preset = '0;
    case (mode)
      MODE_UP_ZERO: preset = '0;
      MODE_DN_NINE: for (int i = 0; i < DIGITS; i++) preset[4*i +: 4] = 4'd9;
      default:      for (int i = 0; i < DIGITS; i++) preset[4*i +: 4] = clamp_digit(init_bcd[4*i +: 4]);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count_bcd <= '0;
      mode_q    <= MODE_UP_ZERO;
    end else if (load) begin
      state     <= ST_IDLE;
      count_bcd <= preset;
      mode_q    <= mode_t'(mode);
    end else begin
      case (state)
        ST_IDLE: if (start && !stop) state <= ST_RUN;
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
          end else if (tick) begin
            if (wrap) begin
              state <= ST_DONE;
            end else begin
              count_bcd <= step_bcd;
              if (next_term) state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign running = (state == ST_RUN);
  assign done    = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed vector table plus hand sequences for the
// BCD stopwatch, covering DIGITS=4 and DIGITS=6 instances.
`default_nettype none

module tb_stopwatch_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] init4 = '0;
  logic [23:0] init6 = '0;
  logic        load = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [15:0] count4;
  logic [23:0] count6;
  logic        running4, done4, running6, done6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_counter #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .init_bcd(init4),
    .load(load), .start(start), .stop(stop), .tick(tick),
    .count_bcd(count4), .running(running4), .done(done4)
  );

  stopwatch_counter #(.DIGITS(6)) dut6 (
    .clk(clk), .rst(rst), .mode(mode), .init_bcd(init6),
    .load(load), .start(start), .stop(stop), .tick(tick),
    .count_bcd(count6), .running(running6), .done(done6)
  );

  typedef struct {
    logic        ld, st, sp, tk;
    logic [1:0]  md;
    logic [15:0] init;
    logic [15:0] exp_cnt;
    logic        exp_run, exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one clock cycle of inputs; returns just after the rising edge.
  task automatic cyc(input logic ld, st, sp, tk, input logic [1:0] md, input logic [15:0] iv);
    @(negedge clk);
    load = ld; start = st; stop = sp; tick = tk; mode = md; init4 = iv;
    @(posedge clk);
    #1;
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic add(input logic ld, st, sp, tk, input logic [1:0] md, input logic [15:0] iv,
                     input logic [15:0] c, input logic r, input logic d);
    vec_t v;
    v.ld = ld; v.st = st; v.sp = sp; v.tk = tk; v.md = md; v.init = iv;
    v.exp_cnt = c; v.exp_run = r; v.exp_done = d;
    vecs.push_back(v);
  endtask

  task automatic chk4(input string nm, input logic [15:0] c, input logic r, input logic d);
    chk({nm, " count"}, {16'h0, count4}, {16'h0, c});
    chk({nm, " running"}, {31'h0, running4}, {31'h0, r});
    chk({nm, " done"}, {31'h0, done4}, {31'h0, d});
  endtask

  initial begin
    //   ld st sp tk md     init      count    run done
    add(0, 0, 0, 1, 2'b00, 16'h0000, 16'h0000, 0, 0); // tick in IDLE ignored
    add(1, 0, 0, 0, 2'b00, 16'h1234, 16'h0000, 0, 0);
    add(0, 0, 0, 1, 2'b00, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 0, 0, 2'b00, 16'h0000, 16'h0000, 1, 0);
    add(0, 0, 0, 1, 2'b00, 16'h0000, 16'h0001, 1, 0);
    add(0, 0, 0, 1, 2'b00, 16'h0000, 16'h0002, 1, 0);
    add(0, 0, 1, 1, 2'b00, 16'h0000, 16'h0002, 0, 0); // stop beats tick
    add(0, 0, 0, 1, 2'b00, 16'h0000, 16'h0002, 0, 0);
    add(0, 1, 0, 0, 2'b00, 16'h0000, 16'h0002, 1, 0);
    add(0, 0, 0, 1, 2'b00, 16'h0000, 16'h0003, 1, 0);
    add(0, 1, 1, 0, 2'b00, 16'h0000, 16'h0003, 0, 0);
    add(0, 1, 1, 0, 2'b00, 16'h0000, 16'h0003, 0, 0); // stop beats start in IDLE
    add(1, 1, 0, 1, 2'b01, 16'h0A0F, 16'h0909, 0, 0); // clamp, load overrides
    add(0, 1, 0, 0, 2'b01, 16'h0000, 16'h0909, 1, 0);
    add(0, 0, 0, 1, 2'b01, 16'h0000, 16'h0910, 1, 0);
    add(1, 0, 0, 0, 2'b10, 16'h0123, 16'h9999, 0, 0);
    add(0, 1, 0, 0, 2'b10, 16'h0000, 16'h9999, 1, 0);
    add(0, 0, 0, 1, 2'b10, 16'h0000, 16'h9998, 1, 0);
    add(0, 0, 0, 1, 2'b10, 16'h0000, 16'h9997, 1, 0);
    add(1, 0, 0, 0, 2'b11, 16'h1000, 16'h1000, 0, 0);
    add(0, 1, 0, 0, 2'b00, 16'h0000, 16'h1000, 1, 0);
    add(0, 0, 0, 1, 2'b00, 16'h0000, 16'h0999, 1, 0); // latched mode keeps down
    add(1, 0, 0, 0, 2'b11, 16'h0001, 16'h0001, 0, 0);
    add(0, 1, 0, 0, 2'b11, 16'h0000, 16'h0001, 1, 0);
    add(0, 0, 0, 1, 2'b11, 16'h0000, 16'h0000, 0, 1);
    add(0, 0, 0, 1, 2'b11, 16'h0000, 16'h0000, 0, 1);
    add(0, 1, 0, 1, 2'b11, 16'h0000, 16'h0000, 0, 1);
    add(0, 0, 1, 0, 2'b11, 16'h0000, 16'h0000, 0, 1);
    add(1, 0, 0, 0, 2'b01, 16'h9999, 16'h9999, 0, 0);
    add(0, 1, 0, 0, 2'b01, 16'h0000, 16'h9999, 1, 0);
    add(0, 0, 0, 1, 2'b01, 16'h0000, 16'h9999, 0, 1); // terminal on entry: no wrap
    add(1, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 0, 0); // load leaves DONE

    #1 rst = 1'b1;
    #2;
    chk4("reset", 16'h0000, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].ld, vecs[i].st, vecs[i].sp, vecs[i].tk, vecs[i].md, vecs[i].init);
      chk4($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_run, vecs[i].exp_done);
    end

    // Up from zero on both widths, then reset mid-count.
    cyc(1, 0, 0, 0, 2'b00, 16'h0000);
    cyc(0, 1, 0, 0, 2'b00, 16'h0000);
    repeat (10) cyc(0, 0, 0, 1, 2'b00, 16'h0000);
    chk4("up10", 16'h0010, 1, 0);
    chk("up10 d6 count", {8'h0, count6}, 32'h000010);
    chk("up10 d6 running", {31'h0, running6}, 32'h1);
    repeat (32) cyc(0, 0, 0, 1, 2'b00, 16'h0000);
    chk4("up42", 16'h0042, 1, 0);
    #1 rst = 1'b1;
    #1;
    chk4("async rst", 16'h0000, 0, 0);
    chk("async rst d6 count", {8'h0, count6}, 32'h0);
    @(negedge clk) rst = 1'b0;
    repeat (3) cyc(0, 0, 0, 1, 2'b00, 16'h0000);
    chk4("tick after rst", 16'h0000, 0, 0);
    cyc(0, 1, 0, 0, 2'b11, 16'h0000);
    cyc(0, 0, 0, 1, 2'b11, 16'h0000);
    chk4("rst mode up", 16'h0001, 1, 0);

    // Down from 0100 to zero, then hold.
    cyc(1, 0, 0, 0, 2'b11, 16'h0100);
    cyc(0, 1, 0, 0, 2'b11, 16'h0000);
    cyc(0, 0, 0, 1, 2'b11, 16'h0000);
    chk4("dn first", 16'h0099, 1, 0);
    repeat (98) cyc(0, 0, 0, 1, 2'b11, 16'h0000);
    chk4("dn 0001", 16'h0001, 1, 0);
    cyc(0, 0, 0, 1, 2'b11, 16'h0000);
    chk4("dn zero", 16'h0000, 0, 1);
    repeat (3) cyc(0, 0, 0, 1, 2'b11, 16'h0000);
    chk4("dn hold", 16'h0000, 0, 1);

    // Up from 9998 reaches 9999 and DONE on the same edge.
    cyc(1, 0, 0, 0, 2'b01, 16'h9998);
    cyc(0, 1, 0, 0, 2'b01, 16'h0000);
    cyc(0, 0, 0, 1, 2'b01, 16'h0000);
    chk4("up 9999", 16'h9999, 0, 1);
    cyc(0, 0, 0, 1, 2'b01, 16'h0000);
    chk4("up 9999 hold", 16'h9999, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
